// File: rtl/prog_sequencer_pkg.sv
// Shared types and default parameters for the program sequencer.
package prog_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PULSE  = 2'd1,
    S_RUN    = 2'd2,
    S_FINISH = 2'd3
  } state_e;

  localparam int DEF_NPROG   = 3;
  localparam int DEF_HOLD    = 4;
  localparam int DEF_CW      = 16;
  localparam int DEF_TIMEOUT = 0;

  // Program index width, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prog_sequencer_if.sv
// Start/Done program handshake plus status, seen from the sequencer (master)
// and from the controlling host (slave).
interface prog_sequencer_if
  import prog_seq_pkg::*;
#(
  parameter int NPROG = DEF_NPROG,
  parameter int CW    = DEF_CW
) ();
  localparam int PW = idx_w(NPROG);

  logic          Go;
  logic          Done;
  logic          Start;
  logic [PW-1:0] ProgIdx;
  logic          Running;
  logic [CW-1:0] CycleCount;
  logic          CountValid;
  logic          TimedOut;
  logic          AllDone;

  modport master (
    input  Go, Done,
    output Start, ProgIdx, Running, CycleCount, CountValid, TimedOut, AllDone
  );

  modport slave (
    output Go, Done,
    input  Start, ProgIdx, Running, CycleCount, CountValid, TimedOut, AllDone
  );
endinterface

// File: rtl/prog_sequencer_sat_counter.sv
// W-bit up counter with synchronous clear and saturation at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;

  // Clear has priority; increment stops once the counter is saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)                       cnt_d = '0;
    else if (en && (cnt_q != '1))  cnt_d = cnt_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/prog_sequencer.sv
// Host-side Start/Done initiator: runs NPROG programs per Go, measures each
// program's RUN length and optionally aborts the sequence on a timeout.
module prog_sequencer
  import prog_seq_pkg::*;
#(
  parameter int NPROG   = DEF_NPROG,
  parameter int HOLD    = DEF_HOLD,
  parameter int CW      = DEF_CW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic           Clk,
  input  logic           ResetN,
  prog_sequencer_if.master bus
);
  localparam int PW = idx_w(NPROG);
  localparam int HW = $clog2(HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
  localparam logic [PW-1:0] IDX_LAST  = PW'(NPROG - 1);
  localparam logic [CW-1:0] TO_VAL    = CW'(TIMEOUT);

  state_e        state_q, state_d;
  logic          start_q, start_d;
  logic          running_q, running_d;
  logic          alldone_q, alldone_d;
  logic          cv_q, cv_d;
  logic          to_q, to_d;
  logic [PW-1:0] idx_q, idx_d;
  logic [CW-1:0] cc_q, cc_d;
  logic [HW-1:0] hold_q, hold_d;

  logic [CW-1:0] run_cnt;
  logic          run_clr, run_en;

  // Run counter restarts on the PULSE->RUN transition and counts RUN edges
  // that see Done low.
  assign run_clr = (state_q == S_PULSE) && (hold_q == HOLD_LAST);
  assign run_en  = (state_q == S_RUN) && !bus.Done;

  sat_counter #(.W(CW)) u_run_cnt (
    .clk   (Clk),
    .rst_n (ResetN),
    .clr   (run_clr),
    .en    (run_en),
    .cnt   (run_cnt)
  );

  // Next-state and next-output logic; every output is a flop so no input
  // reaches a port combinationally.
  always_comb begin
    state_d   = state_q;
    start_d   = start_q;
    running_d = running_q;
    alldone_d = alldone_q;
    cv_d      = 1'b0;
    to_d      = to_q;
    idx_d     = idx_q;
    cc_d      = cc_q;
    hold_d    = hold_q;
    case (state_q)
      S_IDLE, S_FINISH: begin
        if (bus.Go) begin
          state_d   = S_PULSE;
          start_d   = 1'b1;
          running_d = 1'b1;
          alldone_d = 1'b0;
          to_d      = 1'b0;
          idx_d     = '0;
          hold_d    = '0;
        end
      end
      S_PULSE: begin
        // Done is deliberately ignored here: it may still be high from the
        // previous program.
        if (hold_q == HOLD_LAST) begin
          state_d = S_RUN;
          start_d = 1'b0;
          hold_d  = '0;
        end else begin
          hold_d  = hold_q + 1'b1;
        end
      end
      S_RUN: begin
        if (bus.Done) begin
          // Done beats a coincident timeout.
          cc_d = run_cnt;
          cv_d = 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d   = S_FINISH;
            running_d = 1'b0;
            alldone_d = 1'b1;
          end else begin
            state_d = S_PULSE;
            start_d = 1'b1;
            idx_d   = idx_q + 1'b1;
            hold_d  = '0;
          end
        end else if ((TIMEOUT != 0) && (run_cnt == TO_VAL)) begin
          // Abort the whole sequence; remaining programs are skipped.
          cc_d      = TO_VAL;
          cv_d      = 1'b1;
          to_d      = 1'b1;
          state_d   = S_FINISH;
          running_d = 1'b0;
          alldone_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q   <= S_IDLE;
      start_q   <= 1'b0;
      running_q <= 1'b0;
      alldone_q <= 1'b0;
      cv_q      <= 1'b0;
      to_q      <= 1'b0;
      idx_q     <= '0;
      cc_q      <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      running_q <= running_d;
      alldone_q <= alldone_d;
      cv_q      <= cv_d;
      to_q      <= to_d;
      idx_q     <= idx_d;
      cc_q      <= cc_d;
      hold_q    <= hold_d;
    end
  end

  assign bus.Start      = start_q;
  assign bus.ProgIdx    = idx_q;
  assign bus.Running    = running_q;
  assign bus.CycleCount = cc_q;
  assign bus.CountValid = cv_q;
  assign bus.TimedOut   = to_q;
  assign bus.AllDone    = alldone_q;
endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: DUT 0 without timeout, DUT 1 with TIMEOUT=20.
// A host-style driver answers each Start with Done after a chosen number of
// RUN cycles; expected counts come from a per-program reference model.
module tb_prog_sequencer;
  localparam int NP   = 3;
  localparam int HOLD = 4;
  localparam int CW   = 16;
  localparam int TO1  = 20;

  logic Clk;
  logic ResetN;
  logic [1:0] go_r, done_r;

  int checks = 0;
  int errors = 0;

  prog_sequencer_if #(.NPROG(NP), .CW(CW)) if0 ();
  prog_sequencer_if #(.NPROG(NP), .CW(CW)) if1 ();

  assign if0.Go = go_r[0];
  assign if0.Done = done_r[0];
  assign if1.Go = go_r[1];
  assign if1.Done = done_r[1];

  prog_sequencer #(.NPROG(NP), .HOLD(HOLD), .CW(CW), .TIMEOUT(0)) dut0 (
    .Clk(Clk), .ResetN(ResetN), .bus(if0));
  prog_sequencer #(.NPROG(NP), .HOLD(HOLD), .CW(CW), .TIMEOUT(TO1)) dut1 (
    .Clk(Clk), .ResetN(ResetN), .bus(if1));

  logic [1:0] st_w, run_w, cv_w, to_w, ad_w;
  logic [1:0] pidx_w [2];
  logic [CW-1:0] cc_w [2];
  assign st_w  = {if1.Start, if0.Start};
  assign run_w = {if1.Running, if0.Running};
  assign cv_w  = {if1.CountValid, if0.CountValid};
  assign to_w  = {if1.TimedOut, if0.TimedOut};
  assign ad_w  = {if1.AllDone, if0.AllDone};
  assign pidx_w[0] = if0.ProgIdx;
  assign pidx_w[1] = if1.ProgIdx;
  assign cc_w[0] = if0.CycleCount;
  assign cc_w[1] = if1.CycleCount;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [22:0] outs(input int sel);
    return {st_w[sel], pidx_w[sel], run_w[sel], cc_w[sel], cv_w[sel], to_w[sel], ad_w[sel]};
  endfunction

  // One Go on DUT 'sel'; program i answers Done after d_i RUN cycles.
  task automatic run_seq(input int sel, input int d0, input int d1, input int d2,
                         input bit stale, input bit rnd_go);
    int d[3];
    int expv[3];
    int nexp, tmo, npulse, ncv, hi, rem;
    bit exp_to, prev_st, phase, fin;
    logic st, cv, ad, rn, tf;
    logic [1:0] pi;
    logic [CW-1:0] cc;
    d[0] = d0; d[1] = d1; d[2] = d2;
    tmo = (sel == 1) ? TO1 : 0;
    // Reference model: each program reports its Done latency, unless it
    // exceeds a nonzero timeout, which reports the timeout and ends the run.
    nexp = 0; exp_to = 0;
    for (int i = 0; i < NP; i++) begin
      nexp = i + 1;
      if (tmo != 0 && d[i] > tmo) begin
        expv[i] = tmo; exp_to = 1; break;
      end
      expv[i] = d[i];
    end
    @(negedge Clk);
    go_r[sel] = 1'b1; done_r[sel] = stale;
    @(negedge Clk);
    go_r[sel] = 1'b0;
    npulse = 0; ncv = 0; hi = 0; rem = 0;
    prev_st = 0; phase = 0; fin = 0;
    for (int cyc = 0; cyc < 1000 && !fin; cyc++) begin
      if (cyc > 0) @(negedge Clk);
      st = st_w[sel]; cv = cv_w[sel]; ad = ad_w[sel]; rn = run_w[sel];
      tf = to_w[sel]; pi = pidx_w[sel]; cc = cc_w[sel];
      if (st) begin
        if (!prev_st) begin
          npulse++;
          checks++;
          if (pi !== 2'(npulse - 1) || tf !== 1'b0 || rn !== 1'b1) begin
            errors++;
            $display("FAIL pulse_start sel=%0d idx=%0d to=%0b run=%0b want idx=%0d to=0 run=1",
                     sel, pi, tf, rn, npulse - 1);
          end
        end
        hi++;
      end else if (prev_st) begin
        checks++;
        if (hi !== HOLD) begin
          errors++;
          $display("FAIL hold_len sel=%0d got %0d want %0d", sel, hi, HOLD);
        end
        hi = 0; phase = 1;
        rem = (npulse >= 1 && npulse <= NP) ? d[npulse - 1] : 0;
      end
      if (cv) begin
        checks++;
        if (ncv >= nexp || cc !== CW'(expv[ncv])) begin
          errors++;
          $display("FAIL cycle_count sel=%0d n=%0d got %0d want %0d", sel, ncv, cc,
                   (ncv < nexp) ? expv[ncv] : -1);
        end
        ncv++;
        phase = 0; done_r[sel] = stale;
        checks++;
        if (ncv < nexp) begin
          if (st !== 1'b1 || ad !== 1'b0) begin
            errors++;
            $display("FAIL next_start sel=%0d start=%0b alldone=%0b want 1/0", sel, st, ad);
          end
        end else if (ad !== 1'b1 || rn !== 1'b0 || tf !== exp_to) begin
          errors++;
          $display("FAIL finish sel=%0d alldone=%0b run=%0b to=%0b want 1/0/%0b",
                   sel, ad, rn, tf, exp_to);
        end
      end
      if (ad) fin = 1;
      if (phase) begin
        done_r[sel] = (rem == 0);
        if (rem > 0) rem--;
      end
      go_r[sel] = (rnd_go && !ad) ? 1'($urandom % 2) : 1'b0;
      prev_st = st;
    end
    go_r[sel] = 1'b0; done_r[sel] = 1'b0;
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL seq_budget sel=%0d AllDone never seen", sel);
    end
    checks++;
    if (ncv !== nexp || npulse !== nexp || pidx_w[sel] !== 2'(nexp - 1)) begin
      errors++;
      $display("FAIL seq_totals sel=%0d strobes=%0d pulses=%0d idx=%0d want %0d/%0d/%0d",
               sel, ncv, npulse, pidx_w[sel], nexp, nexp, nexp - 1);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      checks++;
      if (st_w[sel] !== 1'b0 || ad_w[sel] !== 1'b1 || cc_w[sel] !== CW'(expv[nexp - 1])) begin
        errors++;
        $display("FAIL finish_hold sel=%0d start=%0b alldone=%0b cc=%0d want 0/1/%0d",
                 sel, st_w[sel], ad_w[sel], cc_w[sel], expv[nexp - 1]);
      end
    end
  endtask

  task automatic test_reset();
    ResetN = 1'b0; go_r = '0; done_r = '0;
    repeat (2) @(negedge Clk);
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (outs(s) !== '0) begin
        errors++;
        $display("FAIL reset_vals sel=%0d got %h want 0", s, outs(s));
      end
    end
    ResetN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      checks++;
      if (outs(0) !== '0 || outs(1) !== '0) begin
        errors++;
        $display("FAIL idle_vals cyc=%0d got %h %h want 0", i, outs(0), outs(1));
      end
    end
  endtask

  task automatic test_nominal();
    run_seq(0, 7, 0, 30, 1'b0, 1'b0);
  endtask

  task automatic test_stale_done();
    run_seq(0, 0, 5, 0, 1'b1, 1'b0);
  endtask

  task automatic test_timeout();
    run_seq(1, 25, 3, 3, 1'b0, 1'b0);
  endtask

  task automatic test_coincide();
    run_seq(1, 20, 4, 20, 1'b0, 1'b0);
  endtask

  task automatic test_restart_after_timeout();
    run_seq(1, 40, 1, 1, 1'b0, 1'b0);
    run_seq(1, 2, 3, 4, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      run_seq(int'($urandom % 2), int'($urandom_range(0, 40)), int'($urandom_range(0, 40)),
              int'($urandom_range(0, 40)), 1'($urandom % 2), 1'b1);
    end
  endtask

  task automatic test_midrun_reset();
    bit found;
    found = 0;
    @(negedge Clk);
    go_r[0] = 1'b1; done_r[0] = 1'b1;
    @(negedge Clk);
    go_r[0] = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge Clk);
      if (pidx_w[0] == 2'd1) done_r[0] = 1'b0;
      if (pidx_w[0] == 2'd1 && st_w[0] == 1'b0 && run_w[0] == 1'b1) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midrun_reach program 1 RUN never seen");
    end
    repeat (3) @(negedge Clk);
    #2 ResetN = 1'b0;
    #1;
    checks++;
    if (outs(0) !== '0 || outs(1) !== '0) begin
      errors++;
      $display("FAIL midrun_reset got %h %h want 0", outs(0), outs(1));
    end
    @(negedge Clk);
    ResetN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      checks++;
      if (outs(0) !== '0) begin
        errors++;
        $display("FAIL post_reset_idle cyc=%0d got %h want 0", i, outs(0));
      end
    end
    run_seq(0, 1, 2, 3, 1'b0, 1'b0);
    run_seq(0, 4, 0, 6, 1'b0, 1'b0);
  endtask

  initial begin
    ResetN = 1'b0; go_r = '0; done_r = '0;
    test_reset();
    test_nominal();
    test_stale_done();
    test_timeout();
    test_coincide();
    test_restart_after_timeout();
    test_random();
    test_midrun_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

- Host-side initiator for the processor's Start/Done program handshake: issues one Start pulse per program, waits for Done, repeats for all NPROG programs.
- Measures each program's run length in clock cycles and flags timeouts.
- Sits between the testbench/top-level control and the processor core; its Start output drives the core's program counter start input.

## Interface
- NPROG, 3: number of programs run back-to-back per Go.
- HOLD, 4: cycles Start is held high per program (≥1).
- CW, 16: cycle-counter width.
- TIMEOUT, 0: max RUN cycles per program; 0 disables timeout.
- Clk  in  1  single clock; all state changes on posedge.
- ResetN  in  1  asynchronous, active-low reset.
- Go  in  1  begin a run of all programs; sampled in IDLE and FINISH only.
- Done  in  1  processor level: current program finished.
- Start  out  1  to processor; registered.
- ProgIdx  out  $clog2(NPROG) (min 1)  index of current/last program.
- Running  out  1  high in PULSE or RUN.
- CycleCount  out  CW  cycle count of last completed program; held until next update.
- CountValid  out  1  one-cycle strobe: CycleCount just updated.
- TimedOut  out  1  sticky: a program hit TIMEOUT.
- AllDone  out  1  high in FINISH.

## Operation
- States: IDLE, PULSE, RUN, FINISH.
- IDLE: Go=1 → PULSE, ProgIdx=0, hold counter=0, TimedOut cleared.
- PULSE: Start=1; hold counter increments; after HOLD cycles → RUN, run counter cleared to 0. Done ignored in PULSE (may be stale from previous program).
- RUN: Start=0; Done=0 → run counter +1, saturating at 2^CW−1. Done=1 → CycleCount ← run counter, CountValid=1 next cycle; if ProgIdx==NPROG−1 → FINISH, else ProgIdx+1 and → PULSE.
- Timeout (TIMEOUT≠0): in RUN with Done=0 and run counter==TIMEOUT → CycleCount ← TIMEOUT, CountValid=1, TimedOut=1, → FINISH (remaining programs skipped).
- Done=1 and timeout condition in same cycle: Done wins, no timeout.
- FINISH: AllDone=1; Go=1 restarts exactly as from IDLE.
- Go in PULSE/RUN ignored.
- Reset values: state IDLE, Start=0, ProgIdx=0, Running=0, CycleCount=0, CountValid=0, TimedOut=0, AllDone=0.

## Timing
- All outputs registered; no combinational input→output paths.
- Go sampled at edge k (IDLE) → Start high from k through edge k+HOLD: exactly HOLD cycles.
- Run counter = number of RUN-state edges with Done=0 before the edge sampling Done=1. Done already high on first RUN edge → CycleCount=0.
- On Done edge m (not last program): CountValid and Start both rise after edge m; no idle gap between programs.
- Last program: AllDone and CountValid rise after the same edge; Running falls then.
- ResetN low at any time, including mid-PULSE or mid-RUN: immediate async return to reset values. Run resumes only on a new Go after release.

## Structure
- Shared package prog_seq_pkg: state enum (IDLE, PULSE, RUN, FINISH) and default-parameter constants.
- One sub-module, sat_counter: CW-bit, sync clear, enable, saturating, async active-low reset.
- Used once for the run counter. The hold counter is inline: width $clog2(HOLD+1).

## Test plan
- Reset/idle: ResetN low, then high with Go=0 for 10 cycles → all outputs 0, Start never asserted.
- Nominal, NPROG=3, HOLD=4, TIMEOUT=0: Go pulse; Done responds 7/0/30 RUN cycles after each Start falls.
  - Start high exactly 4 cycles each, three times.
  - CountValid strobes with CycleCount 7, 0, 30.
  - AllDone=1 after the third; ProgIdx ends at 2.
- Stale Done: Done held high through PULSE → ignored; CycleCount=0 only if still high on the first RUN edge.
- Timeout, TIMEOUT=20: Done never asserted for program 0 → CycleCount=20, TimedOut=1, AllDone=1, ProgIdx=0, no further Start.
- Done and timeout coincide (Done at count 20) → CycleCount=20, TimedOut=0, sequence continues to program 1.
- Mid-run reset and restart:
  - ResetN low during program 1 RUN → outputs at reset values within the same cycle.
  - Then Go from FINISH of a completed run → restarts at ProgIdx=0 with TimedOut cleared.
